// File: rtl/neuron_seq_mac.sv
// Time-multiplexed neuron: out = beta + sum(w*x) over CHUNKS beats of LANES pairs.
// Optional NEURON_SAT_EN clamps the result to the OUT_WIDTH signed range; default wraps.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for start, start_ready=1
// RUN    | accepting chunk beats, in_ready=1
// DRAIN  | letting the product/tree/accumulate pipe empty
// BIAS   | adding beta and registering the narrowed result
// OUT    | result presented until out_ready
module neuron_seq_mac #(
    parameter int LANES     = 28,
    parameter int CHUNKS    = 28,
    parameter int W_WIDTH   = 19,
    parameter int P_WIDTH   = 10,
    parameter int ACC_WIDTH = 48,
    parameter int OUT_WIDTH = 26
) (
    input  logic                          clk,
    input  logic                          GlobalReset,
    input  logic                          start,
    output logic                          start_ready,
    input  logic signed [W_WIDTH-1:0]     beta,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*W_WIDTH-1:0]      in_weight,
    input  logic [LANES*P_WIDTH-1:0]      in_pixel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          busy
);
    localparam int MW    = W_WIDTH + P_WIDTH + 1;
    localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_BIAS, S_OUT} state_t;

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             chunk_cnt;
    logic [1:0]                   drain_cnt;
    logic signed [W_WIDTH-1:0]    beta_r;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  tree_sum;
    logic signed [ACC_WIDTH-1:0]  prod [LANES];
    logic signed [MW-1:0]         mult [LANES];
    logic                         p1_valid, p2_valid;
    logic                         start_acc, beat_acc, last_beat;
    logic signed [OUT_WIDTH-1:0]  result;

    assign start_acc = start & start_ready;
    assign beat_acc  = in_valid & in_ready;
    assign last_beat = beat_acc && (chunk_cnt == LAST_CHUNK);

    always_ff @(posedge clk) begin
        if (!GlobalReset) state <= S_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_acc) state_nxt = S_RUN;
            S_RUN:   if (last_beat) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd0) state_nxt = S_BIAS;
            S_BIAS:  state_nxt = S_OUT;
            S_OUT:   if (out_valid && out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == S_IDLE);
        in_ready    = (state == S_RUN);
        out_valid   = (state == S_OUT);
        busy        = (state != S_IDLE);
    end

    // Pixels are unsigned: a zero MSB keeps them positive in the signed multiply.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mult[i] = MW'($signed(in_weight[i*W_WIDTH +: W_WIDTH]))
                    * MW'($signed({1'b0, in_pixel[i*P_WIDTH +: P_WIDTH]}));
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) tree_sum = tree_sum + prod[i];
    end

    always_ff @(posedge clk) begin
        if (beat_acc) begin
            for (int i = 0; i < LANES; i++) prod[i] <= ACC_WIDTH'(mult[i]);
        end
        if (p1_valid) sum <= tree_sum;
    end

`ifdef NEURON_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH-1:0] total;

    always_comb begin
        total = acc + ACC_WIDTH'(beta_r);
        if (total > SAT_MAX)      result = SAT_MAX[OUT_WIDTH-1:0];
        else if (total < SAT_MIN) result = SAT_MIN[OUT_WIDTH-1:0];
        else                      result = total[OUT_WIDTH-1:0];
    end
`else
    always_comb begin
        result = OUT_WIDTH'(acc + ACC_WIDTH'(beta_r));
    end
`endif

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            acc       <= '0;
            chunk_cnt <= '0;
            drain_cnt <= '0;
            beta_r    <= '0;
            p1_valid  <= 1'b0;
            p2_valid  <= 1'b0;
            out_data  <= '0;
        end else begin
            p1_valid <= beat_acc;
            p2_valid <= p1_valid;
            if (start_acc) begin
                acc       <= '0;
                chunk_cnt <= '0;
                beta_r    <= beta;
            end else begin
                if (p2_valid) acc <= acc + sum;
                if (beat_acc) chunk_cnt <= chunk_cnt + 1'b1;
            end
            // Three DRAIN cycles so the final accumulate lands before BIAS reads acc.
            if (last_beat)
                drain_cnt <= 2'd2;
            else if (state == S_DRAIN && drain_cnt != 2'd0)
                drain_cnt <= drain_cnt - 2'd1;
            if (state == S_BIAS) out_data <= result;
        end
    end
endmodule

// File: tb/tb_neuron_seq_mac.sv
// Directed bench for neuron_seq_mac: default 28x28 instance plus a LANES=4, CHUNKS=1 instance.
`timescale 1ns/1ps

module tb_neuron_seq_mac;
    localparam int L  = 28;
    localparam int WW = 19;
    localparam int PW = 10;
    localparam int OW = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   start_ready;
    logic signed [WW-1:0]   beta = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [L*WW-1:0]        in_weight = '0;
    logic [L*PW-1:0]        in_pixel = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic signed [OW-1:0]   out_data;
    logic                   busy;

    logic                   s_start = 1'b0;
    logic                   s_start_ready;
    logic signed [WW-1:0]   s_beta = '0;
    logic                   s_in_valid = 1'b0;
    logic                   s_in_ready;
    logic [4*WW-1:0]        s_weight = '0;
    logic [4*PW-1:0]        s_pixel = '0;
    logic                   s_out_valid;
    logic                   s_out_ready = 1'b0;
    logic signed [OW-1:0]   s_out_data;
    logic                   s_busy;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    neuron_seq_mac dut (
        .clk(clk), .GlobalReset(rst_n), .start(start), .start_ready(start_ready),
        .beta(beta), .in_valid(in_valid), .in_ready(in_ready), .in_weight(in_weight),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    neuron_seq_mac #(.LANES(4), .CHUNKS(1)) dut_small (
        .clk(clk), .GlobalReset(rst_n), .start(s_start), .start_ready(s_start_ready),
        .beta(s_beta), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_weight(s_weight),
        .in_pixel(s_pixel), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .busy(s_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic signed [WW-1:0] w, input logic [PW-1:0] x);
        for (int i = 0; i < L; i++) begin
            in_weight[i*WW +: WW] = w;
            in_pixel[i*PW +: PW]  = x;
        end
    endtask

    task automatic do_start(input logic signed [WW-1:0] b);
        int t = 0;
        while (!start_ready && t < 50) begin step(); t++; end
        start = 1'b1;
        beta  = b;
        step();
        start = 1'b0;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL start_accept: in_ready=%0b expected 1", in_ready);
        end
    endtask

    // Feeds n accepted beats; gap cycles drive junk data with in_valid low.
    task automatic feed(input int n, input bit gaps, input bit chunk0_only,
                        input logic signed [WW-1:0] w, input logic [PW-1:0] x,
                        output int last_edge);
        int beats = 0;
        int t = 0;
        bit v, r;
        last_edge = -1;
        while (beats < n && t < 400) begin
            v = gaps ? (t % 2 == 0) : 1'b1;
            in_valid = v;
            if (!v)                          set_lanes(19'sd7, 10'd3);
            else if (chunk0_only && beats > 0) set_lanes('0, '0);
            else                             set_lanes(w, x);
            r = in_ready;
            step();
            t++;
            if (v && r) begin beats++; last_edge = cyc; end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int last_edge, output int lat);
        int t = 0;
        while (!out_valid && t < 50) begin step(); t++; end
        lat = cyc - last_edge;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        nvec++; if (out_valid !== 1'b0)   begin nerr++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        nvec++; if (out_data !== '0)      begin nerr++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        nvec++; if (busy !== 1'b0)        begin nerr++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        nvec++; if (in_ready !== 1'b0)    begin nerr++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
        nvec++; if (start_ready !== 1'b1) begin nerr++; $display("FAIL reset_start_ready: got %0b expected 1", start_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int le, lat;
        do_start(19'sd5);
        feed(28, 1'b0, 1'b0, 19'sd1, 10'd2, le);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_in_ready_after_last: got %0b expected 0", in_ready); end
        wait_out(le, lat);
        nvec++; if (lat != 4)        begin nerr++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
        nvec++; if (out_data !== 26'sd1573) begin nerr++; $display("FAIL b2b_data: got %0d expected 1573", out_data); end
        release_out();
        nvec++; if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
            nerr++; $display("FAIL b2b_handshake: out_valid=%0b start_ready=%0b expected 0/1", out_valid, start_ready);
        end
    endtask

    task automatic test_gaps();
        int le, lat;
        do_start(19'sd0);
        feed(28, 1'b1, 1'b0, -19'sd1, 10'd1023, le);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL gaps_beat_count: in_ready=%0b expected 0", in_ready); end
        wait_out(le, lat);
        nvec++; if (out_data !== -26'sd802032) begin nerr++; $display("FAIL gaps_data: got %0d expected -802032", out_data); end
        release_out();
    endtask

    task automatic test_saturation();
        int le, lat;
        int expd;
`ifdef NEURON_SAT_EN
        expd = 33554431;
`else
        expd = -7368676;
`endif
        do_start(19'sd0);
        feed(28, 1'b0, 1'b1, 19'sd262143, 10'd1023, le);
        wait_out(le, lat);
        nvec++; if (int'(out_data) != expd) begin nerr++; $display("FAIL sat_data: got %0d expected %0d", out_data, expd); end
        release_out();
    endtask

    task automatic test_hold();
        int le, lat;
        do_start(19'sd5);
        feed(28, 1'b0, 1'b0, 19'sd1, 10'd2, le);
        wait_out(le, lat);
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            step();
            nvec++;
            if (out_data !== 26'sd1573 || out_valid !== 1'b1 || in_ready !== 1'b0 || start_ready !== 1'b0) begin
                nerr++;
                $display("FAIL hold_stable: data=%0d valid=%0b in_ready=%0b start_ready=%0b expected 1573/1/0/0",
                         out_data, out_valid, in_ready, start_ready);
            end
        end
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL hold_release: valid=%0b start_ready=%0b busy=%0b expected 0/1/0", out_valid, start_ready, busy);
        end
    endtask

    task automatic test_reset_midrun();
        int le, lat;
        do_start(19'sd5);
        feed(10, 1'b0, 1'b0, 19'sd1, 10'd2, le);
        rst_n = 1'b0;
        step();
        nvec++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
            nerr++;
            $display("FAIL midrun_reset_state: busy=%0b sr=%0b ir=%0b ov=%0b od=%0d expected 0/1/0/0/0",
                     busy, start_ready, in_ready, out_valid, out_data);
        end
        rst_n = 1'b1;
        step();
        do_start(19'sd5);
        feed(28, 1'b0, 1'b0, 19'sd1, 10'd2, le);
        wait_out(le, lat);
        nvec++; if (lat != 4)        begin nerr++; $display("FAIL midrun_latency: got %0d expected 4", lat); end
        nvec++; if (out_data !== 26'sd1573) begin nerr++; $display("FAIL midrun_data: got %0d expected 1573", out_data); end
        release_out();
    endtask

    task automatic test_single_chunk();
        int le, t;
        s_start = 1'b1;
        s_beta  = -19'sd3;
        step();
        s_start = 1'b0;
        s_weight = {-19'sd4, 19'sd3, -19'sd2, 19'sd1};
        s_pixel  = {10'd10, 10'd10, 10'd10, 10'd10};
        nvec++; if (s_in_ready !== 1'b1) begin nerr++; $display("FAIL small_in_ready: got %0b expected 1", s_in_ready); end
        s_in_valid = 1'b1;
        step();
        le = cyc;
        s_in_valid = 1'b0;
        nvec++; if (s_in_ready !== 1'b0) begin nerr++; $display("FAIL small_one_beat: in_ready=%0b expected 0", s_in_ready); end
        t = 0;
        while (!s_out_valid && t < 50) begin step(); t++; end
        nvec++; if (cyc - le != 4)        begin nerr++; $display("FAIL small_latency: got %0d expected 4", cyc - le); end
        nvec++; if (s_out_data !== -26'sd23) begin nerr++; $display("FAIL small_data: got %0d expected -23", s_out_data); end
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        nvec++; if (s_out_valid !== 1'b0 || s_start_ready !== 1'b1) begin
            nerr++; $display("FAIL small_handshake: valid=%0b start_ready=%0b expected 0/1", s_out_valid, s_start_ready);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_saturation();
        test_hold();
        test_reset_midrun();
        test_single_chunk();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
